// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - battle state encoding and USB keycodes shared by the battle engine
package battle_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        SELECT = 4'd2,
        ORDER  = 4'd3,
        ATK1   = 4'd4,
        ATK2   = 4'd5,
        CHECK  = 4'd6,
        WIN    = 4'd7,
        LOSE   = 4'd8
    } state_t;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

endpackage

// File: rtl/battle_lfsr.sv
// rtl/battle_lfsr.sv - 16-bit Galois LFSR enemy move picker, built only with BATTLE_LFSR_AI_EN
`ifdef BATTLE_LFSR_AI_EN
module battle_lfsr #(
    parameter int OUT_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] r_lfsr;

    // Right-shifting Galois form of taps 16,14,13,11
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign rnd = r_lfsr[OUT_W-1:0];

endmodule
`endif

// File: rtl/battle_engine.sv
// rtl/battle_engine.sv - turn-based battle controller; BATTLE_LFSR_AI_EN selects LFSR enemy moves
module battle_engine
    import battle_pkg::*;
#(
    parameter int TEAM_SIZE = 3,
    parameter int NUM_MOVES = 4,
    parameter int HP_W      = 8,
    parameter int ID_W      = 3,
    parameter int MOVE_W    = 5,
    parameter int SPD_W     = 8,
    localparam int SLOT_W   = (TEAM_SIZE > 1) ? $clog2(TEAM_SIZE) : 1,
    localparam int MI_W     = $clog2(NUM_MOVES)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        start_battle,
    input  logic [7:0]                  keycode,
    input  logic [TEAM_SIZE*ID_W-1:0]   player_team,
    input  logic [TEAM_SIZE*ID_W-1:0]   enemy_team,
    output logic [ID_W-1:0]             player_id,
    output logic [ID_W-1:0]             enemy_id,
    input  logic [HP_W-1:0]             player_maxhp,
    input  logic [HP_W-1:0]             enemy_maxhp,
    input  logic [SPD_W-1:0]            player_spd,
    input  logic [SPD_W-1:0]            enemy_spd,
    input  logic [NUM_MOVES*MOVE_W-1:0] player_moves,
    input  logic [NUM_MOVES*MOVE_W-1:0] enemy_moves,
    output logic [MOVE_W-1:0]           sel_move_p,
    output logic [MOVE_W-1:0]           sel_move_e,
    output logic                        is_player,
    input  logic [HP_W-1:0]             damage,
    output logic [SLOT_W-1:0]           cur_mon,
    output logic [SLOT_W-1:0]           opp_mon,
    output logic [MI_W-1:0]             move_index,
    output logic [HP_W-1:0]             player_hp,
    output logic [HP_W-1:0]             enemy_hp,
    output logic [3:0]                  state_o,
    output logic                        end_battle,
    output logic                        result
);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_prev_key;
    logic [SLOT_W-1:0] r_load_idx;
    logic [SLOT_W-1:0] r_cur;
    logic [SLOT_W-1:0] r_opp;
    logic [MI_W-1:0]   r_move_idx;
    logic [HP_W-1:0]   r_php [TEAM_SIZE];
    logic [HP_W-1:0]   r_ehp [TEAM_SIZE];
    logic [MOVE_W-1:0] r_sel_p;
    logic [MOVE_W-1:0] r_sel_e;
    logic              r_pfirst;
    logic              r_entry;

    logic              w_press;
    logic              w_enter;
    logic              w_p_attacks;
    logic [HP_W-1:0]   w_att_hp;
    logic [HP_W-1:0]   w_def_hp;
    logic [HP_W-1:0]   w_dmg_hp;
    logic [SLOT_W-1:0] w_p_slot;
    logic [SLOT_W-1:0] w_e_slot;
    logic              w_p_any;
    logic              w_e_any;
    logic [SLOT_W-1:0] w_p_first;
    logic [SLOT_W-1:0] w_e_first;
    logic [MI_W-1:0]   w_ai_idx;

`ifdef BATTLE_LFSR_AI_EN
    battle_lfsr #(
        .OUT_W (MI_W)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .rnd   (w_ai_idx)
    );
`else
    assign w_ai_idx = '0;
`endif

    // A held key produces exactly one press, on the cycle its code first appears
    assign w_press = (keycode != r_prev_key) && (keycode != 8'h00);
    assign w_enter = w_press && (keycode == KEY_ENTER);

    assign w_p_attacks = (r_state == ATK2) ? !r_pfirst : r_pfirst;
    assign w_att_hp    = w_p_attacks ? r_php[r_cur] : r_ehp[r_opp];
    assign w_def_hp    = w_p_attacks ? r_ehp[r_opp] : r_php[r_cur];
    assign w_dmg_hp    = (w_def_hp > damage) ? w_def_hp - damage : '0;

    assign w_p_slot  = (r_state == LOAD) ? r_load_idx : r_cur;
    assign w_e_slot  = (r_state == LOAD) ? r_load_idx : r_opp;
    assign player_id = player_team[w_p_slot*ID_W +: ID_W];
    assign enemy_id  = enemy_team[w_e_slot*ID_W +: ID_W];

    // Lowest-index live slot per side; scanning downward leaves the lowest one
    always_comb begin
        w_p_any   = 1'b0;
        w_e_any   = 1'b0;
        w_p_first = '0;
        w_e_first = '0;
        for (int i = TEAM_SIZE - 1; i >= 0; i--) begin
            if (r_php[i] != '0) begin
                w_p_any   = 1'b1;
                w_p_first = SLOT_W'(i);
            end
            if (r_ehp[i] != '0) begin
                w_e_any   = 1'b1;
                w_e_first = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start_battle) w_next = LOAD;
            LOAD:   if (r_load_idx == SLOT_W'(TEAM_SIZE - 1)) w_next = SELECT;
            SELECT: if (w_enter) w_next = ORDER;
            ORDER:  w_next = ATK1;
            ATK1: begin
                if (r_entry) begin
                    if (w_att_hp == '0) w_next = ATK2;
                end else if (w_enter) begin
                    w_next = (w_def_hp == '0) ? CHECK : ATK2;
                end
            end
            ATK2: begin
                if (r_entry) begin
                    if (w_att_hp == '0) w_next = CHECK;
                end else if (w_enter) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (!w_e_any)      w_next = WIN;
                else if (!w_p_any) w_next = LOSE;
                else               w_next = SELECT;
            end
            WIN:     w_next = IDLE;
            LOSE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_prev_key <= 8'h00;
            r_load_idx <= '0;
            r_cur      <= '0;
            r_opp      <= '0;
            r_move_idx <= '0;
            r_sel_p    <= '0;
            r_sel_e    <= '0;
            r_pfirst   <= 1'b0;
            r_entry    <= 1'b0;
            for (int i = 0; i < TEAM_SIZE; i++) begin
                r_php[i] <= '0;
                r_ehp[i] <= '0;
            end
        end else begin
            r_state    <= w_next;
            r_prev_key <= keycode;
            r_entry    <= (w_next != r_state) && ((w_next == ATK1) || (w_next == ATK2));
            case (r_state)
                IDLE: r_load_idx <= '0;
                LOAD: begin
                    r_php[r_load_idx] <= player_maxhp;
                    r_ehp[r_load_idx] <= enemy_maxhp;
                    r_load_idx        <= r_load_idx + 1'b1;
                    if (r_load_idx == SLOT_W'(TEAM_SIZE - 1)) begin
                        r_cur      <= '0;
                        r_opp      <= '0;
                        r_move_idx <= '0;
                    end
                end
                SELECT: begin
                    if (w_press) begin
                        case (keycode)
                            KEY_W: if (int'(r_move_idx) >= 2) r_move_idx <= r_move_idx - MI_W'(2);
                            KEY_S: if (int'(r_move_idx) + 2 < NUM_MOVES) r_move_idx <= r_move_idx + MI_W'(2);
                            KEY_A: if (r_move_idx[0]) r_move_idx <= r_move_idx - MI_W'(1);
                            KEY_D: if (!r_move_idx[0]) r_move_idx <= r_move_idx + MI_W'(1);
                            default: ;
                        endcase
                    end
                end
                ORDER: begin
                    r_sel_p  <= player_moves[r_move_idx*MOVE_W +: MOVE_W];
                    r_sel_e  <= enemy_moves[w_ai_idx*MOVE_W +: MOVE_W];
                    r_pfirst <= (player_spd >= enemy_spd);
                end
                ATK1, ATK2: begin
                    if (r_entry && (w_att_hp != '0)) begin
                        if (w_p_attacks) r_ehp[r_opp] <= w_dmg_hp;
                        else             r_php[r_cur] <= w_dmg_hp;
                    end
                end
                CHECK: begin
                    if ((r_php[r_cur] == '0) && w_p_any) r_cur <= w_p_first;
                    if ((r_ehp[r_opp] == '0) && w_e_any) r_opp <= w_e_first;
                end
                default: ;
            endcase
        end
    end

    assign sel_move_p = r_sel_p;
    assign sel_move_e = r_sel_e;
    assign is_player  = w_p_attacks;
    assign cur_mon    = r_cur;
    assign opp_mon    = r_opp;
    assign move_index = r_move_idx;
    assign player_hp  = r_php[r_cur];
    assign enemy_hp   = r_ehp[r_opp];
    assign state_o    = r_state;
    assign end_battle = (r_state == WIN) || (r_state == LOSE);
    assign result     = (r_state == WIN);

endmodule

// File: tb/tb_battle_engine.sv
// tb/tb_battle_engine.sv - directed table-driven bench for battle_engine
module tb_battle_engine;
    import battle_pkg::*;

    localparam int TS = 3;
    localparam int NM = 4;
    localparam int HW = 8;
    localparam int IW = 3;
    localparam int MW = 5;
    localparam int SW = 8;

    logic             Clk          = 1'b0;
    logic             Reset        = 1'b1;
    logic             start_battle = 1'b0;
    logic [7:0]       keycode      = 8'h00;
    logic [TS*IW-1:0] player_team  = {3'd3, 3'd2, 3'd1};
    logic [TS*IW-1:0] enemy_team   = {3'd6, 3'd5, 3'd4};
    logic [IW-1:0]    player_id, enemy_id;
    logic [HW-1:0]    player_maxhp, enemy_maxhp;
    logic [HW-1:0]    damage       = '0;
    logic [SW-1:0]    player_spd, enemy_spd;
    logic [NM*MW-1:0] player_moves, enemy_moves;
    logic [MW-1:0]    sel_move_p, sel_move_e;
    logic             is_player;
    logic [1:0]       cur_mon, opp_mon, move_index;
    logic [HW-1:0]    player_hp, enemy_hp;
    logic [3:0]       state_o;
    logic             end_battle, result;

    logic [7:0] hp_rom  [8];
    logic [7:0] spd_rom [8];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] key;
        int         exp_idx;
    } menu_vec_t;
    menu_vec_t mv [20];

    battle_engine dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start_battle (start_battle),
        .keycode      (keycode),
        .player_team  (player_team),
        .enemy_team   (enemy_team),
        .player_id    (player_id),
        .enemy_id     (enemy_id),
        .player_maxhp (player_maxhp),
        .enemy_maxhp  (enemy_maxhp),
        .player_spd   (player_spd),
        .enemy_spd    (enemy_spd),
        .player_moves (player_moves),
        .enemy_moves  (enemy_moves),
        .sel_move_p   (sel_move_p),
        .sel_move_e   (sel_move_e),
        .is_player    (is_player),
        .damage       (damage),
        .cur_mon      (cur_mon),
        .opp_mon      (opp_mon),
        .move_index   (move_index),
        .player_hp    (player_hp),
        .enemy_hp     (enemy_hp),
        .state_o      (state_o),
        .end_battle   (end_battle),
        .result       (result)
    );

    always #5 Clk = ~Clk;

    // Stats ROM model: move j of mon id is {id, j}
    always_comb begin
        player_maxhp = hp_rom[player_id];
        enemy_maxhp  = hp_rom[enemy_id];
        player_spd   = spd_rom[player_id];
        enemy_spd    = spd_rom[enemy_id];
        for (int j = 0; j < NM; j++) begin
            player_moves[j*MW +: MW] = {player_id, 2'(j)};
            enemy_moves[j*MW +: MW]  = {enemy_id, 2'(j)};
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        tick();
        keycode = 8'h00;
        tick();
    endtask

    task automatic start_and_load(input int p0, input int p1, input int p2, input int e0);
        start_battle = 1'b1;
        tick();
        start_battle = 1'b0;
        chk("load_state", state_o, int'(LOAD));
        chk("load_pid0", player_id, p0);
        chk("load_eid0", enemy_id, 4);
        tick();
        chk("load_pid1", player_id, p1);
        tick();
        chk("load_pid2", player_id, p2);
        chk("load_eid2", enemy_id, 6);
        tick();
        chk("load_done_state", state_o, int'(SELECT));
        chk("load_move_idx", move_index, 0);
        chk("load_cur", cur_mon, 0);
        chk("load_opp", opp_mon, 0);
        chk("load_php", player_hp, hp_rom[1]);
        chk("load_ehp", enemy_hp, e0);
    endtask

    task automatic begin_round(input int dmg, input int exp_isp, input int exp_selp, input int exp_sele);
        damage = dmg[HW-1:0];
        press(KEY_ENTER);
        chk("atk1_state", state_o, int'(ATK1));
        chk("atk1_is_player", is_player, exp_isp);
        chk("sel_move_p", sel_move_p, exp_selp);
`ifdef BATTLE_LFSR_AI_EN
        chk("sel_move_e_id", sel_move_e >> 2, exp_sele >> 2);
`else
        chk("sel_move_e", sel_move_e, exp_sele);
`endif
        tick();
    endtask

    task automatic hp_chk(input string tag, input int p, input int e);
        chk({tag, "_php"}, player_hp, p);
        chk({tag, "_ehp"}, enemy_hp, e);
    endtask

    initial begin
        hp_rom  = '{8'd0, 8'd40, 8'd30, 8'd20, 8'd30, 8'd10, 8'd10, 8'd0};
        spd_rom = '{8'd0, 8'd50, 8'd40, 8'd40, 8'd50, 8'd60, 8'd10, 8'd0};

        mv[0]  = '{KEY_D, 1};     mv[1]  = '{KEY_S, 3};
        mv[2]  = '{KEY_D, 3};     mv[3]  = '{KEY_W, 1};
        mv[4]  = '{KEY_A, 0};     mv[5]  = '{KEY_W, 0};
        mv[6]  = '{KEY_A, 0};     mv[7]  = '{KEY_S, 2};
        mv[8]  = '{KEY_S, 2};     mv[9]  = '{KEY_S, 2};
        mv[10] = '{KEY_S, 2};     mv[11] = '{KEY_S, 2};
        mv[12] = '{8'h00, 2};     mv[13] = '{KEY_S, 2};
        mv[14] = '{KEY_D, 3};     mv[15] = '{KEY_D, 3};
        mv[16] = '{8'h00, 3};     mv[17] = '{KEY_D, 3};
        mv[18] = '{KEY_W, 1};     mv[19] = '{8'h00, 1};

        tick();
        tick();
        chk("rst_state", state_o, int'(IDLE));
        chk("rst_php", player_hp, 0);
        chk("rst_ehp", enemy_hp, 0);
        chk("rst_move", move_index, 0);
        chk("rst_end", end_battle, 0);
        chk("rst_result", result, 0);
        Reset = 1'b0;
        tick();
        chk("idle_hold", state_o, int'(IDLE));

        // Battle A: load, menu, then fight through to a win
        start_and_load(1, 2, 3, 30);
        for (int i = 0; i < 20; i++) begin
            keycode = mv[i].key;
            tick();
            chk($sformatf("menu_%0d", i), move_index, mv[i].exp_idx);
        end
        keycode = 8'h00;
        tick();

        begin_round(10, 1, 5, 16);
        hp_chk("r1a", 40, 20);
        press(KEY_ENTER);
        chk("r1_atk2_state", state_o, int'(ATK2));
        chk("r1_atk2_is_player", is_player, 0);
        hp_chk("r1b", 30, 20);
        press(KEY_ENTER);
        chk("r1_end_state", state_o, int'(SELECT));
        chk("r1_move_kept", move_index, 1);

        begin_round(15, 1, 5, 16);
        hp_chk("r2a", 30, 5);
        press(KEY_ENTER);
        hp_chk("r2b", 15, 5);
        press(KEY_ENTER);

        begin_round(12, 1, 5, 16);
        hp_chk("r3a", 15, 0);
        press(KEY_ENTER);
        chk("r3_skip_atk2", state_o, int'(SELECT));
        chk("r3_opp", opp_mon, 1);
        hp_chk("r3b", 15, 10);

        begin_round(20, 0, 5, 20);
        hp_chk("r4a", 0, 10);
        press(KEY_ENTER);
        chk("r4_state", state_o, int'(SELECT));
        chk("r4_cur", cur_mon, 1);
        hp_chk("r4b", 30, 10);

        begin_round(10, 0, 9, 20);
        hp_chk("r5a", 20, 10);
        press(KEY_ENTER);
        hp_chk("r5b", 20, 0);
        press(KEY_ENTER);
        chk("r5_opp", opp_mon, 2);
        chk("r5_cur", cur_mon, 1);
        hp_chk("r5c", 20, 10);

        begin_round(10, 1, 9, 24);
        hp_chk("r6a", 20, 0);
        keycode = KEY_ENTER;
        tick();
        chk("win_check_state", state_o, int'(CHECK));
        chk("win_no_early_end", end_battle, 0);
        keycode = 8'h00;
        tick();
        chk("win_state", state_o, int'(WIN));
        chk("win_end", end_battle, 1);
        chk("win_result", result, 1);
        tick();
        chk("win_idle", state_o, int'(IDLE));
        chk("win_end_pulse", end_battle, 0);
        hp_chk("win_hp_kept", 20, 0);

        // Battle B: faster enemy sweeps the player team
        hp_rom[1]  = 8'd5;
        hp_rom[2]  = 8'd5;
        hp_rom[3]  = 8'd5;
        spd_rom[4] = 8'd60;
        start_and_load(1, 2, 3, 30);
        begin_round(10, 0, 4, 16);
        hp_chk("b1", 0, 30);
        press(KEY_ENTER);
        chk("b1_cur", cur_mon, 1);
        begin_round(10, 0, 8, 16);
        press(KEY_ENTER);
        chk("b2_cur", cur_mon, 2);
        begin_round(10, 0, 12, 16);
        hp_chk("b3", 0, 30);
        press(KEY_ENTER);
        chk("lose_state", state_o, int'(LOSE));
        chk("lose_end", end_battle, 1);
        chk("lose_result", result, 0);
        tick();
        chk("lose_idle", state_o, int'(IDLE));
        chk("lose_end_pulse", end_battle, 0);

        // Battle C: reset while an attack is pending
        start_and_load(1, 2, 3, 30);
        damage = 8'd3;
        press(KEY_ENTER);
        chk("c_atk1", state_o, int'(ATK1));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("c_rst_state", state_o, int'(IDLE));
        chk("c_rst_end", end_battle, 0);
        hp_chk("c_rst", 0, 0);
        chk("c_rst_cur", cur_mon, 0);
        chk("c_rst_move", move_index, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c_no_pulse", end_battle, 0);
        end
        chk("c_stays_idle", state_o, int'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
